bcd_stopwatch_ctrl: RTL



---
 rtl/bcd_stopwatch_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer for a chain of cascaded BCD digits: prescaler, start/stop/clear/lap FSM,
// per-digit carry enables and a lap snapshot register. All outputs are registered.
//
// state | meaning
// IDLE  | count cleared, waiting for start
// RUN   | prescaler advancing, digits step on every tick event
// PAUSE | count and prescaler frozen, start resumes
// DONE  | saturated at all-nines (WRAP=0 only), left only by clear or reset
module bcd_stopwatch_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 10,
   parameter int WRAP       = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    clear,
   input  logic                    lap,
   output logic [4*NUM_DIGITS-1:0] q,
   output logic [4*NUM_DIGITS-1:0] lap_q,
   output logic                    lap_valid,
   output logic                    running,
   output logic                    tick,
   output logic                    overflow
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [1:0]              state;
   logic [PW-1:0]           pre;
   logic [4*NUM_DIGITS-1:0] q_inc;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    all_nine;

   // Codes above 9 are treated as 9 so a corrupted digit rolls over instead of sticking.
   always_comb begin
      q_inc    = q;
      digit_en = '0;
      all_nine = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         digit_en[k] = all_nine;
         if (digit_en[k])
            q_inc[4*k +: 4] = (q[4*k +: 4] >= 4'd9) ? 4'd0 : q[4*k +: 4] + 4'd1;
         all_nine = all_nine && (q[4*k +: 4] >= 4'd9);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         pre       <= '0;
         q         <= '0;
         lap_q     <= '0;
         lap_valid <= 1'b0;
         running   <= 1'b0;
         tick      <= 1'b0;
         overflow  <= 1'b0;
      end else if (clear) begin
         state     <= S_IDLE;
         pre       <= '0;
         q         <= '0;
         lap_q     <= '0;
         lap_valid <= 1'b0;
         running   <= 1'b0;
         tick      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         lap_valid <= 1'b0;
         tick      <= 1'b0;
         if (WRAP != 0)
            overflow <= 1'b0;
         if (lap && state != S_IDLE) begin
            lap_q     <= q;
            lap_valid <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               pre <= '0;
               if (start && !stop) begin
                  state   <= S_RUN;
                  running <= 1'b1;
               end
            end
            S_RUN: begin
               if (stop) begin
                  state   <= S_PAUSE;
                  running <= 1'b0;
               end else if (pre == PRE_LAST) begin
                  pre  <= '0;
                  tick <= 1'b1;
                  if (all_nine) begin
                     overflow <= 1'b1;
                     if (WRAP != 0) begin
                        q <= q_inc;
                     end else begin
                        state   <= S_DONE;
                        running <= 1'b0;
                     end
                  end else begin
                     q <= q_inc;
                  end
               end else begin
                  pre <= pre + 1'b1;
               end
            end
            S_PAUSE: begin
               if (start && !stop) begin
                  state   <= S_RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               pre <= '0;
            end
         endcase
      end
   end

endmodule
